// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core LSU (master) and the data memory (slave).
interface data_mem_responder_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [3:0]        req_be;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, performs it on a word array
// and answers after WAIT_STATES wait cycles so the core's stall path gets exercised.
module data_mem_responder #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                rstn,
   data_mem_responder_if.slave bus
);
   localparam int unsigned WORD_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [3:0]        be;
      logic [31:0]       wdata;
   } req_t;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   req_t               req_q, req_d;
   req_t               req_in_c, cur_req_c;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               req_ready_q, rsp_valid_q;
   logic               commit_c, fault_c, wr_en_c;
   logic [IDX_W-1:0]   word_idx_c;
   logic [WORD_AW-1:0] mem_idx_c;
   logic [31:0]        mem_q [DEPTH_WORDS];

   // In IDLE a zero-wait commit works on the live request, otherwise on the latched copy.
   assign req_in_c   = '{addr: bus.req_addr, we: bus.req_we, be: bus.req_be, wdata: bus.req_wdata};
   assign cur_req_c  = (state_q == IDLE) ? req_in_c : req_q;
   assign word_idx_c = cur_req_c.addr[ADDR_W-1:2];
   assign mem_idx_c  = WORD_AW'(word_idx_c);
   assign fault_c    = (cur_req_c.addr[1:0] != 2'b00) ||
                       (64'(word_idx_c) >= 64'(DEPTH_WORDS));
   assign wr_en_c    = rstn && commit_c && !fault_c && cur_req_c.we;

   // Next state, wait counter and response data captured at the commit edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      commit_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               req_d = req_in_c;
               cnt_d = CNT_W'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  commit_c = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               commit_c = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit_c) begin
         rdata_d = '0;
         err_d   = fault_c;
         if (!fault_c && !cur_req_c.we) begin
            rdata_d = mem_q[mem_idx_c];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= (state_d == IDLE);
         rsp_valid_q <= (state_d == RESP);
      end
   end

   // Array is not reset; only enabled bytes of a fault-free store are written.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_req_c.be[b]) begin
               mem_q[mem_idx_c][8*b +: 8] <= cur_req_c.wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   // A stalled response must not change under the core.
   a_rsp_stable : assert property (@(posedge clk) disable iff (!rstn)
      (bus.rsp_valid && !bus.rsp_ready) |=>
         (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err)));

   a_one_outstanding : assert property (@(posedge clk) disable iff (!rstn)
      !(bus.req_ready && bus.rsp_valid));
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a zero-wait and a two-wait instance checked every cycle
// against a transaction-level model, plus directed cases with literal expectations.
module tb_data_mem_responder;
   localparam int unsigned AW    = 12;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned NDUT  = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(AW)) bus0 ();
   data_mem_responder_if #(.ADDR_W(AW)) bus1 ();

   data_mem_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rstn(rstn), .bus(bus0.slave));
   data_mem_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut1 (
      .clk(clk), .rstn(rstn), .bus(bus1.slave));

   logic          rq_valid [NDUT];
   logic [AW-1:0] rq_addr  [NDUT];
   logic          rq_we    [NDUT];
   logic [3:0]    rq_be    [NDUT];
   logic [31:0]   rq_wdata [NDUT];
   logic          rs_ready [NDUT];
   logic          d_rdy    [NDUT];
   logic          d_val    [NDUT];
   logic          d_err    [NDUT];
   logic [31:0]   d_rdata  [NDUT];

   assign bus0.req_valid = rq_valid[0];  assign bus1.req_valid = rq_valid[1];
   assign bus0.req_addr  = rq_addr[0];   assign bus1.req_addr  = rq_addr[1];
   assign bus0.req_we    = rq_we[0];     assign bus1.req_we    = rq_we[1];
   assign bus0.req_be    = rq_be[0];     assign bus1.req_be    = rq_be[1];
   assign bus0.req_wdata = rq_wdata[0];  assign bus1.req_wdata = rq_wdata[1];
   assign bus0.rsp_ready = rs_ready[0];  assign bus1.rsp_ready = rs_ready[1];
   assign d_rdy[0]   = bus0.req_ready;   assign d_rdy[1]   = bus1.req_ready;
   assign d_val[0]   = bus0.rsp_valid;   assign d_val[1]   = bus1.rsp_valid;
   assign d_err[0]   = bus0.rsp_err;     assign d_err[1]   = bus1.rsp_err;
   assign d_rdata[0] = bus0.rsp_rdata;   assign d_rdata[1] = bus1.rsp_rdata;

   // Transaction-level model: busy flag, edges left until the response, memory image.
   bit            m_busy  [NDUT];
   bit            m_done  [NDUT];
   int            m_left  [NDUT];
   logic [31:0]   m_rdata [NDUT];
   bit            m_err   [NDUT];
   bit            m_we    [NDUT];
   logic [AW-1:0] m_addr  [NDUT];
   logic [3:0]    m_be    [NDUT];
   logic [31:0]   m_wdata [NDUT];
   logic [31:0]   mem_m   [NDUT][DEPTH];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   function automatic int wait_states(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d actual=0x%08h required=0x%08h", name, d, cyc, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < NDUT; d++) begin
         m_busy[d] = 0; m_done[d] = 0; m_left[d] = 0; m_rdata[d] = '0; m_err[d] = 0;
      end
   endfunction

   function automatic void model_commit(int d);
      int unsigned widx = 32'(m_addr[d]) / 4;
      bit          fault = ((32'(m_addr[d]) % 4) != 0) || (widx >= DEPTH);
      logic [31:0] mask = '0;
      m_err[d]   = fault;
      m_rdata[d] = '0;
      if (!fault) begin
         if (m_we[d]) begin
            for (int b = 0; b < 4; b++) if (m_be[d][b]) mask |= 32'hFF << (8 * b);
            mem_m[d][widx] = (mem_m[d][widx] & ~mask) | (m_wdata[d] & mask);
         end else begin
            m_rdata[d] = mem_m[d][widx];
         end
      end
      m_done[d] = 1;
   endfunction

   // Response visible WAIT_STATES+1 edges after acceptance (zero-wait: at the accept edge).
   function automatic void model_edge(int d);
      if (m_busy[d] && m_done[d]) begin
         if (rs_ready[d]) begin m_busy[d] = 0; m_done[d] = 0; end
      end else if (m_busy[d]) begin
         m_left[d]--;
         if (m_left[d] == 0) model_commit(d);
      end else if (rq_valid[d]) begin
         m_busy[d]  = 1;
         m_we[d]    = rq_we[d];
         m_addr[d]  = rq_addr[d];
         m_be[d]    = rq_be[d];
         m_wdata[d] = rq_wdata[d];
         m_left[d]  = (wait_states(d) == 0) ? 0 : wait_states(d) + 1;
         if (m_left[d] == 0) model_commit(d);
      end
   endfunction

   task automatic compare_all();
      for (int d = 0; d < NDUT; d++) begin
         chk("req_ready", d, 32'(d_rdy[d]), 32'(!m_busy[d]));
         chk("rsp_valid", d, 32'(d_val[d]), 32'(m_busy[d] && m_done[d]));
         chk("rsp_rdata", d, d_rdata[d], m_rdata[d]);
         chk("rsp_err",   d, 32'(d_err[d]), 32'(m_err[d]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rstn) for (int d = 0; d < NDUT; d++) model_edge(d);
      compare_all();
   endtask

   // Called 1 time unit after an edge: drops reset mid-cycle, holds it across one edge.
   task automatic reset_pulse();
      #2 rstn = 1'b0;
      model_reset();
      #1 compare_all();
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
      #2 rstn = 1'b1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int unsigned r = $urandom % 10;
      if (r < 7)      return AW'(($urandom % DEPTH) * 4);
      else if (r < 9) return AW'(($urandom % DEPTH) * 4 + 1 + ($urandom % 3));
      else            return AW'(DEPTH * 4 + ($urandom % (4096 - DEPTH * 4)));
   endfunction

   task automatic rand_req(int d);
      rq_we[d]    = 1'($urandom);
      rq_addr[d]  = rand_addr();
      rq_be[d]    = 4'($urandom);
      rq_wdata[d] = $urandom;
   endtask

   task automatic issue(int d, bit we, logic [AW-1:0] a, logic [3:0] be, logic [31:0] wd,
                        output int acc_cyc);
      bit got;
      got = 0;
      rq_valid[d] = 1'b1; rq_we[d] = we; rq_addr[d] = a; rq_be[d] = be; rq_wdata[d] = wd;
      for (int i = 0; i < 40 && !got; i++) begin
         got = d_rdy[d];
         step();
      end
      chk("accept_timeout", d, 32'(got), 32'd1);
      acc_cyc = cyc;
      rq_valid[d] = 1'b0;
      rand_req(d);
   endtask

   task automatic wait_valid(int d, output int lat);
      bit got;
      lat = 0;
      got = d_val[d];
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         lat++;
         got = d_val[d];
      end
      chk("rsp_timeout", d, 32'(got), 32'd1);
   endtask

   task automatic txn(int d, bit we, logic [AW-1:0] a, logic [3:0] be, logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int lat, output int acc);
      rs_ready[d] = 1'b1;
      issue(d, we, a, be, wd, acc);
      wait_valid(d, lat);
      rd = d_rdata[d];
      er = d_err[d];
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat, acc, prev_acc;
      bit          acc_f [NDUT];
      bit          did_rst;

      for (int d = 0; d < NDUT; d++) begin
         rq_valid[d] = 0; rq_addr[d] = '0; rq_we[d] = 0; rq_be[d] = '0; rq_wdata[d] = '0;
         rs_ready[d] = 0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk("reset_req_ready", d, 32'(d_rdy[d]), 32'd1);
         chk("reset_rsp_valid", d, 32'(d_val[d]), 32'd0);
         chk("reset_rsp_rdata", d, d_rdata[d], 32'd0);
         chk("reset_rsp_err",   d, 32'(d_err[d]), 32'd0);
      end
      #2 rstn = 1'b1;

      // Fill both arrays with known data.
      for (int d = 0; d < NDUT; d++)
         for (int w = 0; w < int'(DEPTH); w++)
            txn(d, 1'b1, AW'(w * 4), 4'hF, $urandom, rd, er, lat, acc);

      // Store then load, with the two-wait instance.
      txn(1, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, rd, er, lat, acc);
      chk("t1_store_latency", 1, 32'(lat), 32'd3);
      chk("t1_store_rdata", 1, rd, 32'h0);
      chk("t1_store_err", 1, 32'(er), 32'd0);
      txn(1, 1'b0, 12'h010, 4'h0, 32'h0, rd, er, lat, acc);
      chk("t1_load_rdata", 1, rd, 32'hDEADBEEF);
      chk("t1_load_err", 1, 32'(er), 32'd0);

      // Partial byte-enable store.
      txn(1, 1'b1, 12'h010, 4'b0101, 32'h11223344, rd, er, lat, acc);
      txn(1, 1'b0, 12'h010, 4'hF, 32'h0, rd, er, lat, acc);
      chk("t2_be_merge", 1, rd, 32'hDE22BE44);

      // Faults: misaligned load, out-of-range store leaves the array alone.
      txn(1, 1'b0, 12'h012, 4'hF, 32'h0, rd, er, lat, acc);
      chk("t3_misalign_err", 1, 32'(er), 32'd1);
      chk("t3_misalign_rdata", 1, rd, 32'h0);
      txn(1, 1'b1, AW'(DEPTH * 4), 4'hF, 32'hFFFFFFFF, rd, er, lat, acc);
      chk("t3_oor_err", 1, 32'(er), 32'd1);
      chk("t3_oor_rdata", 1, rd, 32'h0);
      txn(1, 1'b0, 12'h000, 4'hF, 32'h0, rd, er, lat, acc);
      chk("t3_word0", 1, rd, mem_m[1][0]);
      txn(1, 1'b0, AW'((DEPTH - 1) * 4), 4'hF, 32'h0, rd, er, lat, acc);
      chk("t3_last_word", 1, rd, mem_m[1][DEPTH-1]);

      // Backpressure for five cycles.
      rs_ready[1] = 1'b0;
      issue(1, 1'b0, 12'h010, 4'hF, 32'h0, acc);
      wait_valid(1, lat);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_hold_valid", 1, 32'(d_val[1]), 32'd1);
         chk("t4_hold_rdata", 1, d_rdata[1], 32'hDE22BE44);
         chk("t4_hold_err",   1, 32'(d_err[1]), 32'd0);
         chk("t4_hold_ready", 1, 32'(d_rdy[1]), 32'd0);
      end
      rs_ready[1] = 1'b1;
      step();
      chk("t4_release_ready", 1, 32'(d_rdy[1]), 32'd1);
      chk("t4_release_valid", 1, 32'(d_val[1]), 32'd0);

      // Reset one cycle after accepting a store: the store must never land.
      txn(1, 1'b1, 12'h020, 4'hF, 32'h0BADC0DE, rd, er, lat, acc);
      issue(1, 1'b1, 12'h020, 4'hF, 32'hCAFEF00D, acc);
      step();
      reset_pulse();
      chk("t5_rst_ready", 1, 32'(d_rdy[1]), 32'd1);
      chk("t5_rst_valid", 1, 32'(d_val[1]), 32'd0);
      chk("t5_rst_rdata", 1, d_rdata[1], 32'h0);
      chk("t5_rst_err",   1, 32'(d_err[1]), 32'd0);
      step();
      txn(1, 1'b0, 12'h020, 4'hF, 32'h0, rd, er, lat, acc);
      chk("t5_prior_value", 1, rd, 32'h0BADC0DE);

      // Zero-wait instance: back-to-back loads every two cycles.
      txn(0, 1'b1, 12'h008, 4'hF, 32'h55AA33CC, rd, er, lat, acc);
      chk("t6_store_latency", 0, 32'(lat), 32'd0);
      prev_acc = acc;
      for (int i = 0; i < 4; i++) begin
         txn(0, 1'b0, 12'h008, 4'hF, 32'h0, rd, er, lat, acc);
         chk("t6_load_latency", 0, 32'(lat), 32'd0);
         chk("t6_spacing", 0, 32'(acc - prev_acc), 32'd2);
         chk("t6_load_rdata", 0, rd, 32'h55AA33CC);
         prev_acc = acc;
      end

      // Random traffic on both instances, occasional reset.
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < NDUT; d++) begin
            if (!rq_valid[d] && ($urandom % 3 == 0)) begin
               rq_valid[d] = 1'b1;
               rand_req(d);
            end
            rs_ready[d] = ($urandom % 4) != 0;
            acc_f[d] = rq_valid[d] && d_rdy[d];
         end
         did_rst = ($urandom % 400) == 0;
         if (did_rst) reset_pulse();
         else step();
         for (int d = 0; d < NDUT; d++) begin
            if (acc_f[d] && !did_rst) begin
               rq_valid[d] = 1'($urandom);
               rand_req(d);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
